// File: rtl/radar_data_tx.sv
// Rendezvous-radar data source model: serialises a selected 15-bit radar
// word MSB first as RRIN1/RRIN0 pulses, one bit per rising RRSYNC edge.
module radar_data_tx #(
    parameter int WORD_BITS   = 15,
    parameter int PULSE_CYC   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RRSYNC,
    input  logic                 RRRANG,
    input  logic                 RRRARA,
    input  logic                 range_load,
    input  logic                 rate_load,
    input  logic [WORD_BITS-1:0] load_data,
    output logic                 RRIN0,
    output logic                 RRIN1,
    output logic                 busy,
    output logic                 word_sent,
    output logic                 aborted,
    output logic                 overrun,
    output logic                 range_valid,
    output logic                 rate_valid
);

    localparam int CW = $clog2(WORD_BITS + 1);
    localparam int PW = $clog2(PULSE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_RANGE = 2'd1,
        SRC_RATE  = 2'd2
    } src_t;

    state_t               r_state, w_state_n;
    src_t                 r_src, w_src_n;
    logic [WORD_BITS-1:0] r_shift, w_shift_n;
    logic [CW-1:0]        r_bit_cnt, w_bit_cnt_n;
    logic [PW-1:0]        r_pulse_cnt, w_pulse_cnt_n;
    logic [TW-1:0]        r_tmo_cnt, w_tmo_cnt_n;
    logic                 r_pending, w_pending_n;
    // Source register was reloaded after the latch: its new contents are unsent.
    logic                 r_dirty, w_dirty_n;
    logic                 r_overrun, w_overrun_n;
    logic                 r_busy, w_busy_n;
    logic                 r_word_sent, w_word_sent_n;
    logic                 r_aborted, w_aborted_n;
    logic                 r_rrin0, w_rrin0_n;
    logic                 r_rrin1, w_rrin1_n;
    logic                 r_sync_q;
    logic [WORD_BITS-1:0] r_range, r_rate;
    logic                 r_range_valid, r_rate_valid;
    logic                 w_clr_range, w_clr_rate;
    logic                 w_sync_edge;
    logic                 w_src_load;

    assign w_sync_edge = RRSYNC & ~r_sync_q;
    assign w_src_load  = ((r_src == SRC_RANGE) & range_load) |
                         ((r_src == SRC_RATE)  & rate_load);

    // Next-state and next-output logic for the transmit FSM.
    always_comb begin
        w_state_n     = r_state;
        w_src_n       = r_src;
        w_shift_n     = r_shift;
        w_bit_cnt_n   = r_bit_cnt;
        w_pulse_cnt_n = r_pulse_cnt;
        w_tmo_cnt_n   = r_tmo_cnt;
        w_pending_n   = r_pending;
        w_dirty_n     = r_dirty | w_src_load;
        w_overrun_n   = r_overrun;
        w_busy_n      = r_busy;
        w_word_sent_n = 1'b0;
        w_aborted_n   = 1'b0;
        w_clr_range   = 1'b0;
        w_clr_rate    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_sync_edge) begin
                    // Selection is sampled only here; the latch takes the old
                    // holding value if a load lands on the same cycle.
                    case ({RRRANG, RRRARA})
                        2'b10: begin
                            w_shift_n = r_range;
                            w_src_n   = SRC_RANGE;
                            w_dirty_n = range_load;
                        end
                        2'b01: begin
                            w_shift_n = r_rate;
                            w_src_n   = SRC_RATE;
                            w_dirty_n = rate_load;
                        end
                        default: begin
                            w_shift_n = '0;
                            w_src_n   = SRC_NONE;
                            w_dirty_n = 1'b0;
                        end
                    endcase
                    w_bit_cnt_n   = '0;
                    w_pulse_cnt_n = '0;
                    w_tmo_cnt_n   = '0;
                    w_pending_n   = 1'b0;
                    w_busy_n      = 1'b1;
                    w_state_n     = ST_PULSE;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end

            ST_PULSE: begin
                if (r_pulse_cnt == PW'(PULSE_CYC - 1)) begin
                    w_shift_n     = {r_shift[WORD_BITS-2:0], 1'b0};
                    w_bit_cnt_n   = r_bit_cnt + 1'b1;
                    w_pulse_cnt_n = '0;
                    w_tmo_cnt_n   = '0;
                    if (r_bit_cnt == CW'(WORD_BITS - 1)) begin
                        w_word_sent_n = 1'b1;
                        w_busy_n      = 1'b0;
                        w_state_n     = ST_IDLE;
                        w_pending_n   = 1'b0;
                        w_clr_range   = (r_src == SRC_RANGE) & ~w_dirty_n;
                        w_clr_rate    = (r_src == SRC_RATE)  & ~w_dirty_n;
                        // A queued or coincident edge has no word left to serve.
                        if (r_pending | w_sync_edge) begin
                            w_overrun_n = 1'b1;
                        end else begin
                            w_overrun_n = r_overrun;
                        end
                    end else if (r_pending) begin
                        w_state_n   = ST_PULSE;
                        w_pending_n = w_sync_edge;
                    end else begin
                        w_state_n   = ST_WAIT;
                        w_pending_n = w_sync_edge;
                    end
                end else begin
                    w_pulse_cnt_n = r_pulse_cnt + 1'b1;
                    if (w_sync_edge) begin
                        if (r_pending) begin
                            w_overrun_n = 1'b1;
                        end else begin
                            w_pending_n = 1'b1;
                        end
                    end else begin
                        w_pending_n = r_pending;
                    end
                end
            end

            ST_WAIT: begin
                if (w_sync_edge | r_pending) begin
                    w_state_n     = ST_PULSE;
                    w_pulse_cnt_n = '0;
                    w_tmo_cnt_n   = '0;
                    w_pending_n   = r_pending & w_sync_edge;
                end else if (r_tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    w_aborted_n = 1'b1;
                    w_busy_n    = 1'b0;
                    w_tmo_cnt_n = '0;
                    w_state_n   = ST_IDLE;
                end else begin
                    w_tmo_cnt_n = r_tmo_cnt + 1'b1;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase

        w_rrin1_n = (w_state_n == ST_PULSE) &  w_shift_n[WORD_BITS-1];
        w_rrin0_n = (w_state_n == ST_PULSE) & ~w_shift_n[WORD_BITS-1];
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_src       <= SRC_NONE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_pulse_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_pending   <= 1'b0;
            r_dirty     <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
            r_word_sent <= 1'b0;
            r_aborted   <= 1'b0;
            r_rrin0     <= 1'b0;
            r_rrin1     <= 1'b0;
            r_sync_q    <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_src       <= w_src_n;
            r_shift     <= w_shift_n;
            r_bit_cnt   <= w_bit_cnt_n;
            r_pulse_cnt <= w_pulse_cnt_n;
            r_tmo_cnt   <= w_tmo_cnt_n;
            r_pending   <= w_pending_n;
            r_dirty     <= w_dirty_n;
            r_overrun   <= w_overrun_n;
            r_busy      <= w_busy_n;
            r_word_sent <= w_word_sent_n;
            r_aborted   <= w_aborted_n;
            r_rrin0     <= w_rrin0_n;
            r_rrin1     <= w_rrin1_n;
            r_sync_q    <= RRSYNC;
        end
    end

    // Holding registers and their valid flags; a load always beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range       <= '0;
            r_rate        <= '0;
            r_range_valid <= 1'b0;
            r_rate_valid  <= 1'b0;
        end else begin
            if (range_load) begin
                r_range       <= load_data;
                r_range_valid <= 1'b1;
            end else if (w_clr_range) begin
                r_range_valid <= 1'b0;
            end else begin
                r_range_valid <= r_range_valid;
            end
            if (rate_load) begin
                r_rate       <= load_data;
                r_rate_valid <= 1'b1;
            end else if (w_clr_rate) begin
                r_rate_valid <= 1'b0;
            end else begin
                r_rate_valid <= r_rate_valid;
            end
        end
    end

    assign RRIN0       = r_rrin0;
    assign RRIN1       = r_rrin1;
    assign busy        = r_busy;
    assign word_sent   = r_word_sent;
    assign aborted     = r_aborted;
    assign overrun     = r_overrun;
    assign range_valid = r_range_valid;
    assign rate_valid  = r_rate_valid;

endmodule

// File: tb/tb_radar_data_tx.sv
// Directed bench for radar_data_tx: one task per scenario, inline checks.
module tb_radar_data_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RRSYNC = 1'b0;
    logic        RRRANG = 1'b0;
    logic        RRRARA = 1'b0;
    logic        range_load = 1'b0;
    logic        rate_load = 1'b0;
    logic [14:0] load_data = 15'h0000;
    logic        RRIN0, RRIN1, busy, word_sent, aborted, overrun, range_valid, rate_valid;

    int n_tests = 0;
    int n_fail  = 0;

    radar_data_tx dut (
        .clk(clk), .rst(rst), .RRSYNC(RRSYNC), .RRRANG(RRRANG), .RRRARA(RRRARA),
        .range_load(range_load), .rate_load(rate_load), .load_data(load_data),
        .RRIN0(RRIN0), .RRIN1(RRIN1), .busy(busy), .word_sent(word_sent),
        .aborted(aborted), .overrun(overrun), .range_valid(range_valid),
        .rate_valid(rate_valid)
    );

    always #5 clk = ~clk;

    // One sync edge; samples the pulse on the three negedges after the edge.
    task automatic sync_bit(input int gap, input logic ld, input logic [14:0] ldv,
                            output logic f1, output logic f0, output int hi,
                            output int both, output logic ws);
        @(negedge clk);
        RRSYNC = 1'b1;
        if (ld) begin
            range_load = 1'b1;
            load_data  = ldv;
        end
        hi = 0; both = 0; ws = 1'b0; f1 = 1'b0; f0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                RRSYNC = 1'b0;
                range_load = 1'b0;
                f1 = RRIN1;
                f0 = RRIN0;
            end
            if (RRIN1 | RRIN0) hi++;
            if (RRIN1 & RRIN0) both++;
            if (word_sent) ws = 1'b1;
        end
        repeat (gap - 4) @(negedge clk);
    endtask

    // n syncs, collecting first-cycle RRIN1/RRIN0 samples MSB first.
    task automatic send_word(input int n, input int gap, input logic ld, input logic [14:0] ldv,
                             output logic [14:0] w1, output logic [14:0] w0, output int hi,
                             output int both, output int ws_cnt, output logic ws_last);
        logic f1, f0, ws;
        int h, b;
        w1 = 15'h0000; w0 = 15'h0000; hi = 0; both = 0; ws_cnt = 0; ws_last = 1'b0;
        for (int i = 0; i < n; i++) begin
            sync_bit(gap, ld && (i == 0), ldv, f1, f0, h, b, ws);
            w1 = {w1[13:0], f1};
            w0 = {w0[13:0], f0};
            hi += h;
            both += b;
            if (ws) ws_cnt++;
            ws_last = ws;
        end
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if ({RRIN0, RRIN1, busy, word_sent, aborted, overrun, range_valid, rate_valid} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {RRIN0, RRIN1, busy, word_sent, aborted, overrun, range_valid, rate_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_range_word;
        logic [14:0] w1, w0; int hi, both, wsc; logic wsl;
        @(negedge clk); RRRANG = 1'b1; RRRARA = 1'b0; range_load = 1'b1; load_data = 15'h5A5A;
        @(negedge clk); range_load = 1'b0;
        n_tests++;
        if (range_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid_set: got %b expected 1", range_valid); end
        send_word(15, 10, 1'b0, 15'h0000, w1, w0, hi, both, wsc, wsl);
        n_tests++;
        if (w1 !== 15'h5A5A) begin n_fail++; $display("FAIL t1_rrin1_bits: got %h expected 5a5a", w1); end
        n_tests++;
        if (w0 !== 15'h25A5) begin n_fail++; $display("FAIL t1_rrin0_bits: got %h expected 25a5", w0); end
        n_tests++;
        if (hi !== 30) begin n_fail++; $display("FAIL t1_pulse_cycles: got %0d expected 30", hi); end
        n_tests++;
        if (both !== 0) begin n_fail++; $display("FAIL t1_both_high: got %0d expected 0", both); end
        n_tests++;
        if (wsc !== 1 || wsl !== 1'b1) begin n_fail++; $display("FAIL t1_word_sent: got cnt %0d last %b expected 1 1", wsc, wsl); end
        n_tests++;
        if ({range_valid, busy, overrun} !== 3'b000) begin n_fail++; $display("FAIL t1_end_flags: got %b expected 000", {range_valid, busy, overrun}); end
    endtask

    task automatic test_back_to_back;
        int c1, c0, cws;
        logic ov_mid;
        @(negedge clk); RRRANG = 1'b0; RRRARA = 1'b1; rate_load = 1'b1; load_data = 15'h7FFF;
        @(negedge clk); rate_load = 1'b0;
        c1 = 0; c0 = 0; cws = 0; ov_mid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (RRIN1) c1++;
            if (RRIN0) c0++;
            if (word_sent) cws++;
            if (i == 20) ov_mid = overrun;
            RRSYNC = (i < 32) && (i % 2 == 0);
        end
        n_tests++;
        if (c1 !== 30) begin n_fail++; $display("FAIL t2_rrin1_cycles: got %0d expected 30", c1); end
        n_tests++;
        if (c0 !== 0) begin n_fail++; $display("FAIL t2_rrin0_cycles: got %0d expected 0", c0); end
        n_tests++;
        if (cws !== 1) begin n_fail++; $display("FAIL t2_word_sent: got %0d expected 1", cws); end
        n_tests++;
        if (ov_mid !== 1'b0) begin n_fail++; $display("FAIL t2_overrun_mid: got %b expected 0", ov_mid); end
        n_tests++;
        if ({overrun, rate_valid, busy} !== 3'b100) begin n_fail++; $display("FAIL t2_end_flags: got %b expected 100", {overrun, rate_valid, busy}); end
    endtask

    task automatic test_both_selected;
        logic [14:0] w1, w0; int hi, both, wsc; logic wsl;
        @(negedge clk); range_load = 1'b1; rate_load = 1'b1; load_data = 15'h1234;
        @(negedge clk); range_load = 1'b0; rate_load = 1'b0; RRRANG = 1'b1; RRRARA = 1'b1;
        n_tests++;
        if ({range_valid, rate_valid} !== 2'b11) begin n_fail++; $display("FAIL t3_dual_load: got %b expected 11", {range_valid, rate_valid}); end
        send_word(15, 10, 1'b0, 15'h0000, w1, w0, hi, both, wsc, wsl);
        n_tests++;
        if (w1 !== 15'h0000 || w0 !== 15'h7FFF) begin n_fail++; $display("FAIL t3_zero_word: got rrin1 %h rrin0 %h expected 0000 7fff", w1, w0); end
        n_tests++;
        if (hi !== 30 || wsl !== 1'b1) begin n_fail++; $display("FAIL t3_pulses: got %0d ws %b expected 30 1", hi, wsl); end
        n_tests++;
        if ({range_valid, rate_valid} !== 2'b11) begin n_fail++; $display("FAIL t3_valid_kept: got %b expected 11", {range_valid, rate_valid}); end
    endtask

    task automatic test_timeout;
        logic [14:0] w1, w0; int hi, both, wsc; logic wsl;
        int k_ab, n_ab; logic busy_ab;
        @(negedge clk); RRRANG = 1'b1; RRRARA = 1'b0; range_load = 1'b1; load_data = 15'h4000;
        @(negedge clk); range_load = 1'b0;
        send_word(3, 10, 1'b0, 15'h0000, w1, w0, hi, both, wsc, wsl);
        n_tests++;
        if (w1 !== 15'h0004 || w0 !== 15'h0003) begin n_fail++; $display("FAIL t4_first_bits: got %h %h expected 0004 0003", w1, w0); end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL t4_busy_mid: got %b expected 1", busy); end
        k_ab = -1; n_ab = 0; busy_ab = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (aborted) begin
                n_ab++;
                if (k_ab < 0) begin k_ab = k; busy_ab = busy; end
            end
        end
        n_tests++;
        if (k_ab !== 58 || n_ab !== 1) begin n_fail++; $display("FAIL t4_abort_time: got at %0d count %0d expected 58 1", k_ab, n_ab); end
        n_tests++;
        if (busy_ab !== 1'b0 || range_valid !== 1'b1) begin n_fail++; $display("FAIL t4_abort_flags: got busy %b valid %b expected 0 1", busy_ab, range_valid); end
        send_word(15, 10, 1'b0, 15'h0000, w1, w0, hi, both, wsc, wsl);
        n_tests++;
        if (w1 !== 15'h4000 || w0 !== 15'h3FFF) begin n_fail++; $display("FAIL t4_restart_word: got %h %h expected 4000 3fff", w1, w0); end
        n_tests++;
        if (range_valid !== 1'b0 || wsl !== 1'b1) begin n_fail++; $display("FAIL t4_restart_end: got valid %b ws %b expected 0 1", range_valid, wsl); end
    endtask

    task automatic test_load_at_latch;
        logic [14:0] w1, w0; int hi, both, wsc; logic wsl;
        @(negedge clk); RRRANG = 1'b1; RRRARA = 1'b0; range_load = 1'b1; load_data = 15'h7FFE;
        @(negedge clk); range_load = 1'b0;
        send_word(15, 10, 1'b1, 15'h0001, w1, w0, hi, both, wsc, wsl);
        n_tests++;
        if (w1 !== 15'h7FFE || w0 !== 15'h0001) begin n_fail++; $display("FAIL t5_old_value: got %h %h expected 7ffe 0001", w1, w0); end
        n_tests++;
        if (wsl !== 1'b1 || range_valid !== 1'b1) begin n_fail++; $display("FAIL t5_valid_kept: got ws %b valid %b expected 1 1", wsl, range_valid); end
    endtask

    task automatic test_reset_midword;
        logic [14:0] w1, w0; int hi, both, wsc; logic wsl;
        RRRANG = 1'b1; RRRARA = 1'b0;
        send_word(2, 10, 1'b0, 15'h0000, w1, w0, hi, both, wsc, wsl);
        n_tests++;
        if (w0 !== 15'h0003 || busy !== 1'b1) begin n_fail++; $display("FAIL t6_pre_bits: got %h busy %b expected 0003 1", w0, busy); end
        @(negedge clk); RRSYNC = 1'b1;
        @(negedge clk); RRSYNC = 1'b0;
        n_tests++;
        if (RRIN0 !== 1'b1) begin n_fail++; $display("FAIL t6_third_pulse: got %b expected 1", RRIN0); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({RRIN0, RRIN1, busy, overrun, range_valid, rate_valid} !== 6'b000000) begin
            n_fail++;
            $display("FAIL t6_async_clear: got %b expected 000000", {RRIN0, RRIN1, busy, overrun, range_valid, rate_valid});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_word(15, 10, 1'b0, 15'h0000, w1, w0, hi, both, wsc, wsl);
        n_tests++;
        if (w1 !== 15'h0000 || w0 !== 15'h7FFF || wsl !== 1'b1) begin n_fail++; $display("FAIL t6_zero_word: got %h %h ws %b expected 0000 7fff 1", w1, w0, wsl); end
        n_tests++;
        if (overrun !== 1'b0 || range_valid !== 1'b0) begin n_fail++; $display("FAIL t6_post_flags: got %b %b expected 0 0", overrun, range_valid); end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset;
        test_range_word;
        test_back_to_back;
        test_both_selected;
        test_timeout;
        test_load_at_latch;
        test_reset_midword;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
